// File: rtl/mrd_stage_sequencer.sv
// Frame sequencer for the mixed-radix DFT memory engine: walks one frame
// through sink, one read/write pass per factor stage, and source.
module mrd_stage_sequencer #(
  parameter int WAIT_RD_CYC = 4,
  parameter int MAX_NF      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       sink_valid,
  input  logic       sink_sop,
  input  logic       sink_eop,
  input  logic [2:0] num_of_factors,
  input  logic       rd_end,
  input  logic       wr_end,
  input  logic       source_end,
  output logic [2:0] fsm,
  output logic [2:0] fsm_r,
  output logic [2:0] cnt_stage,
  output logic [2:0] nf_lat,
  output logic       sink_ready,
  output logic       stage_start,
  output logic       frame_done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SINK    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_RD      = 3'd3,
    ST_WAIT_WR = 3'd4,
    ST_SOURCE  = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_RD_CYC - 1);
  localparam logic [2:0] NF_MAX    = 3'(MAX_NF);

  state_t     r_fsm, w_fsm_next;
  logic [2:0] r_fsm_r;
  logic [2:0] r_cnt_stage, w_cnt_next;
  logic [2:0] r_nf_lat, w_nf_next;
  logic [3:0] r_wait_cnt, w_wait_next;
  logic       r_wr_pend, w_wr_pend_next;
  logic       r_stage_start, w_stage_start_next;
  logic       r_frame_done, w_frame_done_next;
  logic       r_cfg_err, w_cfg_err_next;
  logic       w_sop, w_nf_ok, w_last_stage;

  assign w_sop        = sink_valid && sink_sop;
  assign w_nf_ok      = (num_of_factors != 3'd0) && (num_of_factors <= NF_MAX);
  assign w_last_stage = (r_cnt_stage == (r_nf_lat - 3'd1));

  always_comb begin
    w_fsm_next        = r_fsm;
    w_cnt_next        = r_cnt_stage;
    w_nf_next         = r_nf_lat;
    w_wait_next       = r_wait_cnt;
    w_wr_pend_next    = r_wr_pend;
    w_frame_done_next = 1'b0;
    w_cfg_err_next    = 1'b0;
    if (clr) begin
      w_fsm_next     = ST_IDLE;
      w_cnt_next     = 3'd0;
      w_wait_next    = 4'd0;
      w_wr_pend_next = 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_sop) begin
            if (w_nf_ok) begin
              w_nf_next  = num_of_factors;
              w_cnt_next = 3'd0;
              // A single-sample frame skips Sink entirely.
              if (sink_eop) begin
                w_fsm_next  = ST_WAIT_RD;
                w_wait_next = WAIT_LOAD;
              end else begin
                w_fsm_next = ST_SINK;
              end
            end else begin
              w_cfg_err_next = 1'b1;
            end
          end
        end
        ST_SINK: begin
          if (sink_valid && sink_eop) begin
            w_fsm_next  = ST_WAIT_RD;
            w_wait_next = WAIT_LOAD;
          end
        end
        ST_WAIT_RD: begin
          if (r_wait_cnt == 4'd0) begin
            w_fsm_next = ST_RD;
          end else begin
            w_wait_next = r_wait_cnt - 4'd1;
          end
        end
        ST_RD: begin
          // Write-back may finish before or with the read; remember it.
          if (wr_end) w_wr_pend_next = 1'b1;
          if (rd_end) w_fsm_next = ST_WAIT_WR;
        end
        ST_WAIT_WR: begin
          if (wr_end || r_wr_pend) begin
            w_wr_pend_next = 1'b0;
            if (w_last_stage) begin
              w_fsm_next = ST_SOURCE;
            end else begin
              w_cnt_next  = r_cnt_stage + 3'd1;
              w_wait_next = WAIT_LOAD;
              w_fsm_next  = ST_WAIT_RD;
            end
          end
        end
        ST_SOURCE: begin
          if (source_end) begin
            w_fsm_next        = ST_IDLE;
            w_cnt_next        = 3'd0;
            w_frame_done_next = 1'b1;
          end
        end
        default: w_fsm_next = ST_IDLE;
      endcase
    end
    w_stage_start_next = (w_fsm_next == ST_RD) && (r_fsm != ST_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm         <= ST_IDLE;
      r_fsm_r       <= 3'd0;
      r_cnt_stage   <= 3'd0;
      r_nf_lat      <= 3'd1;
      r_wait_cnt    <= 4'd0;
      r_wr_pend     <= 1'b0;
      r_stage_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_fsm         <= w_fsm_next;
      r_fsm_r       <= r_fsm;
      r_cnt_stage   <= w_cnt_next;
      r_nf_lat      <= w_nf_next;
      r_wait_cnt    <= w_wait_next;
      r_wr_pend     <= w_wr_pend_next;
      r_stage_start <= w_stage_start_next;
      r_frame_done  <= w_frame_done_next;
      r_cfg_err     <= w_cfg_err_next;
    end
  end

  assign fsm         = r_fsm;
  assign fsm_r       = r_fsm_r;
  assign cnt_stage   = r_cnt_stage;
  assign nf_lat      = r_nf_lat;
  assign stage_start = r_stage_start;
  assign frame_done  = r_frame_done;
  assign cfg_err     = r_cfg_err;
  assign sink_ready  = ((r_fsm == ST_IDLE) || (r_fsm == ST_SINK)) && !clr;

endmodule

// File: tb/tb_mrd_stage_sequencer.sv
// Directed bench for mrd_stage_sequencer: full frames, config rejects,
// stray pulses, soft abort and asynchronous reset.
module tb_mrd_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       sink_valid = 1'b0;
  logic       sink_sop = 1'b0;
  logic       sink_eop = 1'b0;
  logic [2:0] num_of_factors = 3'd0;
  logic       rd_end = 1'b0;
  logic       wr_end = 1'b0;
  logic       source_end = 1'b0;
  logic [2:0] fsm, fsm_r, cnt_stage, nf_lat;
  logic       sink_ready, stage_start, frame_done, cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mrd_stage_sequencer #(.WAIT_RD_CYC(4), .MAX_NF(6)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .num_of_factors(num_of_factors),
    .rd_end(rd_end), .wr_end(wr_end), .source_end(source_end),
    .fsm(fsm), .fsm_r(fsm_r), .cnt_stage(cnt_stage), .nf_lat(nf_lat),
    .sink_ready(sink_ready), .stage_start(stage_start),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered while fsm shows Wait_to_rd; measures dwell until Rd.
  task automatic wait_rd(input int exp_dwell, input logic [2:0] exp_cnt);
    int n;
    n = 0;
    while (fsm == 3'd2 && n < 40) begin
      step(1);
      n++;
    end
    chk("wait_dwell", 8'(n), 8'(exp_dwell));
    chk("rd_entry_fsm", 8'(fsm), 8'd3);
    chk("stage_start_high", 8'(stage_start), 8'd1);
    chk("rd_cnt_stage", 8'(cnt_stage), 8'(exp_cnt));
    $display("stage %0d entered Rd after %0d wait cycles", exp_cnt, n);
  endtask

  task automatic do_stage(input logic [2:0] cnt, input bit last);
    wait_rd(4, cnt);
    step(1);
    chk("stage_start_low", 8'(stage_start), 8'd0);
    chk("rd_hold", 8'(fsm), 8'd3);
    step(18);
    rd_end = 1'b1;
    step(1);
    rd_end = 1'b0;
    chk("rd_to_wait_wr", 8'(fsm), 8'd4);
    step(4);
    chk("wait_wr_hold", 8'(fsm), 8'd4);
    wr_end = 1'b1;
    step(1);
    wr_end = 1'b0;
    if (last) begin
      chk("to_source", 8'(fsm), 8'd5);
      chk("source_cnt", 8'(cnt_stage), 8'(cnt));
    end else begin
      chk("to_wait_rd", 8'(fsm), 8'd2);
      chk("cnt_incr", 8'(cnt_stage), 8'(cnt + 3'd1));
    end
  endtask

  task automatic do_source();
    step(15);
    chk("source_hold", 8'(fsm), 8'd5);
    source_end = 1'b1;
    step(1);
    source_end = 1'b0;
    chk("source_to_idle", 8'(fsm), 8'd0);
    chk("frame_done_pulse", 8'(frame_done), 8'd1);
    chk("idle_cnt", 8'(cnt_stage), 8'd0);
    step(1);
    chk("frame_done_low", 8'(frame_done), 8'd0);
    chk("fsm_r_idle", 8'(fsm_r), 8'd0);
    $display("frame complete");
  endtask

  task automatic start_short(input logic [2:0] nf);
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b1; num_of_factors = nf;
    step(1);
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    chk("short_to_wait", 8'(fsm), 8'd2);
    chk("short_nf_lat", 8'(nf_lat), 8'(nf));
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fsm", 8'(fsm), 8'd0);
    chk("rst_fsm_r", 8'(fsm_r), 8'd0);
    chk("rst_cnt", 8'(cnt_stage), 8'd0);
    chk("rst_nf_lat", 8'(nf_lat), 8'd1);
    chk("rst_pulses", 8'({stage_start, frame_done, cfg_err}), 8'd0);
    chk("rst_sink_ready", 8'(sink_ready), 8'd1);
    rst_n = 1'b1;
    step(1);

    // Frame with nf=3, 16 samples
    sink_valid = 1'b1; sink_sop = 1'b1; num_of_factors = 3'd3;
    step(1);
    sink_sop = 1'b0;
    chk("sop_to_sink", 8'(fsm), 8'd1);
    chk("nf_lat_3", 8'(nf_lat), 8'd3);
    chk("sink_ready_sink", 8'(sink_ready), 8'd1);
    step(14);
    chk("sink_hold", 8'(fsm), 8'd1);
    sink_eop = 1'b1;
    step(1);
    sink_eop = 1'b0; sink_valid = 1'b0;
    chk("eop_to_wait", 8'(fsm), 8'd2);
    chk("sink_ready_wait", 8'(sink_ready), 8'd0);
    do_stage(3'd0, 1'b0);
    do_stage(3'd1, 1'b0);
    do_stage(3'd2, 1'b1);
    do_source();

    // Rejected configurations, then accepted nf=6
    sink_valid = 1'b1; sink_sop = 1'b1; num_of_factors = 3'd0;
    step(1);
    chk("cfg_err_nf0", 8'(cfg_err), 8'd1);
    chk("nf0_fsm", 8'(fsm), 8'd0);
    chk("nf0_nf_lat", 8'(nf_lat), 8'd3);
    num_of_factors = 3'd7;
    step(1);
    chk("cfg_err_nf7", 8'(cfg_err), 8'd1);
    chk("nf7_fsm", 8'(fsm), 8'd0);
    chk("nf7_nf_lat", 8'(nf_lat), 8'd3);
    chk("nf7_sink_ready", 8'(sink_ready), 8'd1);
    num_of_factors = 3'd6;
    step(1);
    sink_sop = 1'b0; sink_valid = 1'b0;
    chk("nf6_fsm", 8'(fsm), 8'd1);
    chk("nf6_nf_lat", 8'(nf_lat), 8'd6);
    chk("nf6_cfg_err_low", 8'(cfg_err), 8'd0);
    chk("nf6_sink_ready", 8'(sink_ready), 8'd1);

    // Stray pulses in Sink, a second sop in Sink
    wr_end = 1'b1; rd_end = 1'b1; source_end = 1'b1;
    step(1);
    wr_end = 1'b0; rd_end = 1'b0; source_end = 1'b0;
    chk("stray_sink_fsm", 8'(fsm), 8'd1);
    chk("stray_sink_cnt", 8'(cnt_stage), 8'd0);
    sink_valid = 1'b1; sink_sop = 1'b1; num_of_factors = 3'd2;
    step(1);
    sink_sop = 1'b0;
    chk("sop_in_sink_fsm", 8'(fsm), 8'd1);
    chk("sop_in_sink_nf", 8'(nf_lat), 8'd6);
    sink_eop = 1'b1;
    step(1);
    sink_eop = 1'b0; sink_valid = 1'b0;
    chk("eop2_to_wait", 8'(fsm), 8'd2);
    rd_end = 1'b1;
    step(1);
    rd_end = 1'b0;
    chk("stray_rd_end_wait", 8'(fsm), 8'd2);
    wait_rd(3, 3'd0);
    source_end = 1'b1; sink_valid = 1'b1; sink_eop = 1'b1;
    step(1);
    source_end = 1'b0; sink_valid = 1'b0; sink_eop = 1'b0;
    chk("stray_rd_fsm", 8'(fsm), 8'd3);
    chk("stray_rd_cnt", 8'(cnt_stage), 8'd0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_rd_abort", 8'(fsm), 8'd0);

    // nf=1, rd_end with wr_end in the same cycle
    start_short(3'd1);
    wait_rd(4, 3'd0);
    step(2);
    rd_end = 1'b1; wr_end = 1'b1;
    step(1);
    rd_end = 1'b0; wr_end = 1'b0;
    chk("pend_wait_wr", 8'(fsm), 8'd4);
    step(1);
    chk("pend_to_source", 8'(fsm), 8'd5);
    chk("pend_cnt", 8'(cnt_stage), 8'd0);
    do_source();

    // clr during Rd of stage 1 with nf=4
    start_short(3'd4);
    do_stage(3'd0, 1'b0);
    wait_rd(4, 3'd1);
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_fsm", 8'(fsm), 8'd0);
    chk("clr_cnt", 8'(cnt_stage), 8'd0);
    chk("clr_no_frame_done", 8'(frame_done), 8'd0);
    step(1);
    chk("clr_no_frame_done_2", 8'(frame_done), 8'd0);
    clr = 1'b1;
    #1;
    chk("clr_sink_ready", 8'(sink_ready), 8'd0);
    step(1);
    clr = 1'b0;
    #1;
    chk("sink_ready_after_clr", 8'(sink_ready), 8'd1);
    start_short(3'd2);
    do_stage(3'd0, 1'b0);
    do_stage(3'd1, 1'b1);
    do_source();

    // Asynchronous reset in Wait_wr_end
    start_short(3'd1);
    wait_rd(4, 3'd0);
    rd_end = 1'b1;
    step(1);
    rd_end = 1'b0;
    chk("pre_rst_fsm", 8'(fsm), 8'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fsm", 8'(fsm), 8'd0);
    chk("async_rst_fsm_r", 8'(fsm_r), 8'd0);
    chk("async_rst_nf", 8'(nf_lat), 8'd1);
    chk("async_rst_cnt", 8'(cnt_stage), 8'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_fsm", 8'(fsm), 8'd0);
    chk("post_rst_fsm_r", 8'(fsm_r), 8'd0);
    chk("post_rst_sink_ready", 8'(sink_ready), 8'd1);
    wr_end = 1'b1;
    step(1);
    wr_end = 1'b0;
    chk("post_rst_stays_idle", 8'(fsm), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
